boot_loader: RTL and testbench

- Upstream boot stage for the 6502 core.
- Receives a program image as a byte stream and writes it into system memory through a write port.
- Optionally writes the reset vector at FFFC/FFFD, then releases the core's reset.
- The core's first VECTOR fetch therefore sees the freshly loaded image.

---
 rtl/boot_loader.sv | 217 +++++++++++++++++++++
 tb/tb_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader
//   Upstream boot stage for the 6502 core. Receives a program image as a byte
//   stream (load address LSB/MSB, length LSB/MSB, N data bytes, checksum),
//   writes the data into system memory, optionally writes the reset vector at
//   FFFC/FFFD, and then releases the core's reset after RELEASE_DELAY cycles.
//
//   Optional feature macro: BOOT_LOADER_VECTOR_EN
//     defined   - after a valid checksum, FFFC/FFFD are written with the load
//                 address so the core starts at the freshly loaded image.
//     undefined - a valid checksum goes straight to the release delay; the
//                 image must carry its own FFFC/FFFD bytes.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   resetn      asynchronous active-low reset
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader accepts a byte (transfer = in_valid && in_ready)
//   mem_we      memory write strobe, one cycle per written byte
//   mem_addr    memory write address
//   mem_wdata   memory write data
//   cpu_resetn  active-low reset to the processor core
//   done        image loaded, core running
//   err         checksum mismatch, core held in reset
module boot_loader #(
   parameter int RELEASE_DELAY = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        cpu_resetn,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      ADDR_L,
      ADDR_H,
      LEN_L,
      LEN_H,
      DATA,
      CSUM,
      VEC_L,
      VEC_H,
      HOLD,
      RUN,
      ERROR
   } state_t;

   // HOLD lasts RELEASE_DELAY cycles: the counter runs 0..RELEASE_DELAY-1.
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(RELEASE_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [7:0]       sum;
   logic [7:0]       sum_next;
   logic [7:0]       csum_total;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_next;
   logic [15:0]      load_addr;
   logic [15:0]      load_addr_next;
   logic [15:0]      ptr;
   logic [15:0]      ptr_next;
   logic [15:0]      remaining;
   logic [15:0]      remaining_next;
   logic             mem_we_next;
   logic [15:0]      mem_addr_next;
   logic [7:0]       mem_wdata_next;
   logic             accept;

   function automatic logic takes_input(input state_t s);
      return (s == ADDR_L) || (s == ADDR_H) || (s == LEN_L) ||
             (s == LEN_H)  || (s == DATA)   || (s == CSUM);
   endfunction

   // Flags and in_ready are registered from the next state, so they change on
   // the same edge that enters the state they describe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ADDR_L;
         sum        <= 8'h00;
         counter    <= '0;
         load_addr  <= 16'h0000;
         ptr        <= 16'h0000;
         remaining  <= 16'h0000;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 16'h0000;
         mem_wdata  <= 8'h00;
         cpu_resetn <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_next;
         sum        <= sum_next;
         counter    <= counter_next;
         load_addr  <= load_addr_next;
         ptr        <= ptr_next;
         remaining  <= remaining_next;
         in_ready   <= takes_input(state_next);
         mem_we     <= mem_we_next;
         mem_addr   <= mem_addr_next;
         mem_wdata  <= mem_wdata_next;
         cpu_resetn <= (state_next == RUN);
         done       <= (state_next == RUN);
         err        <= (state_next == ERROR);
      end
   end

   always_comb begin
      state_next     = state;
      sum_next       = sum;
      counter_next   = counter;
      load_addr_next = load_addr;
      ptr_next       = ptr;
      remaining_next = remaining;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr;
      mem_wdata_next = mem_wdata;
      accept         = in_valid && in_ready;
      csum_total     = sum + in_data;

      if (accept) begin
         sum_next = csum_total;
      end

      case (state)
         ADDR_L: begin
            if (accept) begin
               load_addr_next[7:0] = in_data;
               state_next          = ADDR_H;
            end
         end
         ADDR_H: begin
            if (accept) begin
               load_addr_next[15:8] = in_data;
               ptr_next             = {in_data, load_addr[7:0]};
               state_next           = LEN_L;
            end
         end
         LEN_L: begin
            if (accept) begin
               remaining_next[7:0] = in_data;
               state_next          = LEN_H;
            end
         end
         LEN_H: begin
            if (accept) begin
               remaining_next[15:8] = in_data;
               state_next = ({in_data, remaining[7:0]} != 16'h0000) ? DATA : CSUM;
            end
         end
         DATA: begin
            if (accept) begin
               mem_we_next    = 1'b1;
               mem_addr_next  = ptr;
               mem_wdata_next = in_data;
               ptr_next       = ptr + 16'd1;
               remaining_next = remaining - 16'd1;
               if (remaining == 16'd1) begin
                  state_next = CSUM;
               end
            end
         end
         CSUM: begin
            // Valid image: all accepted bytes including the checksum sum to 0.
            if (accept) begin
               if (csum_total == 8'h00) begin
`ifdef BOOT_LOADER_VECTOR_EN
                  state_next = VEC_L;
`else
                  state_next = HOLD;
`endif
               end else begin
                  state_next = ERROR;
               end
            end
         end
         VEC_L: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = 16'hFFFC;
            mem_wdata_next = load_addr[7:0];
            state_next     = VEC_H;
         end
         VEC_H: begin
            mem_we_next    = 1'b1;
            mem_addr_next  = 16'hFFFD;
            mem_wdata_next = load_addr[15:8];
            state_next     = HOLD;
         end
         HOLD: begin
            if (counter == LAST_COUNT) begin
               state_next = RUN;
            end else begin
               counter_next = counter + CNT_ONE;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         ERROR: begin
            state_next = ERROR;
         end
         default: begin
            state_next = ADDR_L;
         end
      endcase
   end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader
//   Self-checking bench for boot_loader. Images are streamed in, every memory
//   write is logged with the cycle it appears in, and the log is compared with
//   a reference derived from the stream format: parse header, sum all bytes,
//   list the writes each accepted byte must cause and when the core must be
//   released.
module tb_boot_loader;

   localparam int RD = 4;
`ifdef BOOT_LOADER_VECTOR_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_resetn;
   logic        done;
   logic        err;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_cr = 1'b0;

   wr_t  wr_q[$];
   int   wr_cyc_q[$];
   int   rise_q[$];
   int   acc_q[$];

   wr_t  exp_wr[$];
   int   exp_cyc[$];
   bit   exp_ok;
   int   exp_rise;

   boot_loader #(
      .RELEASE_DELAY(RD),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_resetn(cpu_resetn),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log writes and cpu_resetn rising edges mid-cycle, away from the clock edge.
   always @(negedge clk) begin
      if (resetn && mem_we) begin
         wr_q.push_back({mem_addr, mem_wdata});
         wr_cyc_q.push_back(cyc);
      end
      if (cpu_resetn && !prev_cr) begin
         rise_q.push_back(cyc);
      end
      prev_cr <= cpu_resetn;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] csumOf(input byte_q_t q);
      logic [7:0] t;
      t = 8'h00;
      foreach (q[i]) t = t + q[i];
      return 8'h00 - t;
   endfunction

   task automatic doReset();
      @(negedge clk);
      #2;
      resetn   = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      checkOutput("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      checkOutput("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      #2;
      resetn = 1'b1;
      wr_q.delete();
      wr_cyc_q.delete();
      rise_q.delete();
      acc_q.delete();
      @(negedge clk);
      checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic sendByte(input logic [7:0] b, output int acc);
      int waited;
      waited = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
         acc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
      end
      in_valid = 1'b0;
   endtask

   task automatic applyStimulus(input byte_q_t s, input int gap);
      int a;
      for (int i = 0; i < s.size(); i++) begin
         sendByte(s[i], a);
         acc_q.push_back(a);
         repeat (gap) @(negedge clk);
      end
   endtask

   // Reference: what the stream format says must happen, given when each
   // byte was actually accepted.
   task automatic modelImage(input byte_q_t s);
      logic [15:0] a;
      int          n;
      int          csum_c;
      logic [7:0]  t;
      exp_wr.delete();
      exp_cyc.delete();
      a = {s[1], s[0]};
      n = int'({s[3], s[2]});
      t = 8'h00;
      foreach (s[i]) t = t + s[i];
      exp_ok = (t == 8'h00);
      for (int i = 0; i < n; i++) begin
         exp_wr.push_back({16'(a + 16'(i)), s[4 + i]});
         exp_cyc.push_back(acc_q[4 + i]);
      end
      csum_c = acc_q[4 + n];
      if (exp_ok && VEC_EN) begin
         exp_wr.push_back({16'hFFFC, s[0]});
         exp_cyc.push_back(csum_c + 1);
         exp_wr.push_back({16'hFFFD, s[1]});
         exp_cyc.push_back(csum_c + 2);
      end
      exp_rise = csum_c + RD + (VEC_EN ? 2 : 0);
   endtask

   task automatic checkImage(input string tag, input byte_q_t s);
      int waited;
      int n0;
      waited = 0;
      while (!(done || err) && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      repeat (2) @(negedge clk);
      modelImage(s);
      checkOutput({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
      for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
         checkOutput({tag, "_wr"}, {8'd0, wr_q[i]}, {8'd0, exp_wr[i]});
         checkOutput({tag, "_wr_cyc"}, wr_cyc_q[i], exp_cyc[i]);
      end
      checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, exp_ok});
      checkOutput({tag, "_cpu_resetn"}, {31'd0, cpu_resetn}, {31'd0, exp_ok});
      checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, !exp_ok});
      checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      if (exp_ok) begin
         checkOutput({tag, "_rise_count"}, rise_q.size(), 32'd1);
         if (rise_q.size() > 0) checkOutput({tag, "_release_cyc"}, rise_q[0], exp_rise);
      end else begin
         checkOutput({tag, "_rise_count"}, rise_q.size(), 32'd0);
      end
      // Bytes offered in a terminal state must be ignored.
      n0 = wr_q.size();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_data  = 8'($urandom);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_ignored_wr"}, wr_q.size(), n0);
      checkOutput({tag, "_ignored_ready"}, {31'd0, in_ready}, 32'd0);
      checkOutput({tag, "_ignored_done"}, {31'd0, done}, {31'd0, exp_ok});
   endtask

   task automatic runImage(input string tag, input byte_q_t s, input int gap);
      doReset();
      applyStimulus(s, gap);
      checkImage(tag, s);
   endtask

   initial begin
      byte_q_t     s;
      byte_q_t     nominal;
      logic [15:0] a;
      int          n;
      int          dummy;
      logic [7:0]  c;

      $display("[TB] boot_loader bench start, vector writes %0s", VEC_EN ? "on" : "off");

      nominal = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h05, 8'hEA, 8'h63};
      runImage("nominal", nominal, 0);

      s = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hA9, 8'h05, 8'hEA, 8'h64};
      runImage("bad_csum", s, 0);

      s = '{8'h00, 8'h10, 8'h00, 8'h00, 8'hF0};
      runImage("zero_len", s, 0);

      s = '{8'hFE, 8'hFF, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
      s.push_back(csumOf(s));
      runImage("addr_wrap", s, 0);

      runImage("gaps", nominal, 3);

      // Abandon a load after the second data byte, then replay it whole.
      doReset();
      for (int i = 0; i < 6; i++) sendByte(nominal[i], dummy);
      @(negedge clk);
      checkOutput("mid_we_before_reset", {31'd0, mem_we}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("mid_we_async", {31'd0, mem_we}, 32'd0);
      checkOutput("mid_ready_async", {31'd0, in_ready}, 32'd0);
      checkOutput("mid_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
      runImage("replay", nominal, 0);

      // A running core must drop into reset without waiting for a clock edge.
      @(negedge clk);
      checkOutput("run_cpu_resetn_high", {31'd0, cpu_resetn}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("async_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
      checkOutput("async_done", {31'd0, done}, 32'd0);

      for (int k = 0; k < 6; k++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 2) == 0) a = 16'hFFFD;
         n = $urandom_range(0, 5);
         s = '{a[7:0], a[15:8], 8'(n), 8'h00};
         for (int i = 0; i < n; i++) s.push_back(8'($urandom));
         c = csumOf(s);
         if ($urandom_range(0, 3) == 0) c = c + 8'(1 + $urandom_range(0, 254));
         s.push_back(c);
         runImage("random", s, $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
